// File: rtl/fft_pkg.sv
// Shared constants and elaboration-time helpers for the streaming radix-2^2 SDF FFT.
package fft_pkg;

  localparam int unsigned LOG_N        = 6;
  localparam int unsigned STAGE_TW_LAT = 2;

  // BF1 delay exponent of stage s: D1 = N / 2^(2s+1)
  function automatic int unsigned stage_log_d(input int unsigned stage);
    return LOG_N - 1 - 2 * stage;
  endfunction

  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sdf_frame_cnt.sv
// Enable-gated wrapping frame counter with a compare strobe against a mark value.
module sdf_frame_cnt #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] mark,
  output logic [WIDTH-1:0] cnt,
  output logic             hit_c
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  // High in the enabled cycle whose count equals mark
  assign hit_c = en && (cnt == mark);

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sample sequencer for one radix-2^2 SDF stage: mux selects, -j, twiddle address, valid strobes.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG_D  = stage_log_d(0),
  parameter int unsigned TW_LAT = STAGE_TW_LAT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           di_en,
  output logic           bf1_sel,
  output logic           bf1_en,
  output logic           bf1_mj,
  output logic           bf2_sel,
  output logic           bf2_en,
  output logic [LOG_D:0] tw_addr,
  output logic           do_en,
  output logic           err
);

  localparam int unsigned CW = LOG_D + 1;
  localparam int unsigned D1 = 2 ** LOG_D;
  localparam int unsigned D2 = D1 / 2;
  localparam logic [CW-1:0] D1_MARK  = CW'(D1 - 1);
  localparam logic [CW-1:0] D2_MARK  = CW'(D2 - 1);
  localparam logic [CW-1:0] END_MARK = {CW{1'b1}};

  logic [CW-1:0]     di_cnt;
  logic [CW-1:0]     bf1_cnt;
  logic [CW-1:0]     b2_cnt;
  logic [CW-1:0]     bf2_cnt;
  logic              b2_en;
  logic              bf1_start_c;
  logic              bf1_end_c;
  logic              bf2_start_c;
  logic              bf2_end_c;
  logic [TW_LAT-1:0] do_sr;
  logic [CW-1:0]     tw_prod_c;

  sdf_frame_cnt #(.WIDTH(CW)) u_di_cnt (
    .clock (clock),
    .reset (reset),
    .en    (di_en),
    .mark  (D1_MARK),
    .cnt   (di_cnt),
    .hit_c (bf1_start_c)
  );

  sdf_frame_cnt #(.WIDTH(CW)) u_bf1_cnt (
    .clock (clock),
    .reset (reset),
    .en    (bf1_en),
    .mark  (END_MARK),
    .cnt   (bf1_cnt),
    .hit_c (bf1_end_c)
  );

  sdf_frame_cnt #(.WIDTH(CW)) u_bf2_cnt (
    .clock (clock),
    .reset (reset),
    .en    (bf2_en),
    .mark  (END_MARK),
    .cnt   (bf2_cnt),
    .hit_c (bf2_end_c)
  );

  // BF2 opens its window once its delay line holds D2 samples of the BF1 stream
  assign bf2_start_c = b2_en && (b2_cnt == D2_MARK);

  // Windows run a full frame once started so the delay lines always drain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bf1_en <= 1'b0;
      b2_en  <= 1'b0;
      b2_cnt <= '0;
      bf2_en <= 1'b0;
      do_sr  <= '0;
      err    <= 1'b0;
    end else begin
      bf1_en <= bf1_start_c | (bf1_en & ~bf1_end_c);
      b2_en  <= bf1_en;
      b2_cnt <= bf1_cnt;
      bf2_en <= bf2_start_c | (bf2_en & ~bf2_end_c);
      do_sr  <= TW_LAT'({do_sr, bf2_en});
      err    <= err | (~di_en & (di_cnt != '0));
    end
  end

  // Twiddle exponent: index within quarter times bit-reversed quarter number
  assign tw_prod_c = CW'(bf2_cnt[LOG_D-2:0]) * CW'({bf2_cnt[LOG_D-1], bf2_cnt[LOG_D]});

  assign bf1_sel = di_cnt[LOG_D];
  assign bf1_mj  = bf1_en & (&bf1_cnt[LOG_D -: 2]);
  assign bf2_sel = b2_en & b2_cnt[LOG_D-1];
  assign tw_addr = bf2_en ? tw_prod_c : '0;
  assign do_en   = do_sr[TW_LAT-1];

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Randomized frame-timing bench for sdf_stage_ctrl against a frame-start schedule model.
module tb_sdf_stage_ctrl;

  localparam int LOG_D  = 5;
  localparam int TW_LAT = 2;
  localparam int D1     = 32;
  localparam int D2     = 16;
  localparam int F      = 64;

  logic       clock;
  logic       reset;
  logic       di_en;
  logic       bf1_sel;
  logic       bf1_en;
  logic       bf1_mj;
  logic       bf2_sel;
  logic       bf2_en;
  logic [5:0] tw_addr;
  logic       do_en;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sent     = 0;
  int do_cnt   = 0;
  int nfr      = 0;
  bit err_exp  = 1'b0;
  bit track    = 1'b1;
  int starts[$];

  sdf_stage_ctrl #(.LOG_D(LOG_D), .TW_LAT(TW_LAT)) dut (
    .clock   (clock),
    .reset   (reset),
    .di_en   (di_en),
    .bf1_sel (bf1_sel),
    .bf1_en  (bf1_en),
    .bf1_mj  (bf1_mj),
    .bf2_sel (bf2_sel),
    .bf2_en  (bf2_en),
    .tw_addr (tw_addr),
    .do_en   (do_en),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int brev2(input int q);
    return ((q & 1) << 1) | ((q >> 1) & 1);
  endfunction

  // One clock: compare this cycle against the schedule, then drive inputs for it
  task automatic step(input logic d, input logic r);
    int e_sel1, e_en1, e_mj, e_sel2, e_en2, e_tw, e_do;
    int rel, j;
    @(posedge clock);
    #1;
    e_sel1 = 0; e_en1 = 0; e_mj = 0; e_sel2 = 0; e_en2 = 0; e_tw = 0; e_do = 0;
    foreach (starts[i]) begin
      rel = cyc - starts[i];
      if (rel >= D1 && rel < F) e_sel1 = 1;
      j = rel - D1;
      if (j >= 0 && j < F) begin
        e_en1 = 1;
        if (j >= F - F / 4) e_mj = 1;
      end
      j = rel - (D1 + 1);
      if (j >= 0 && j < F && ((j / D2) % 2) == 1) e_sel2 = 1;
      j = rel - (D1 + 1 + D2);
      if (j >= 0 && j < F) begin
        e_en2 = 1;
        e_tw  = ((j % D2) * brev2(j / D2)) % F;
      end
      j = rel - (D1 + 1 + D2 + TW_LAT);
      if (j >= 0 && j < F) e_do = 1;
    end
    if (track) begin
      check_val("bf1_sel", 32'(bf1_sel), e_sel1);
      check_val("bf1_en",  32'(bf1_en),  e_en1);
      check_val("bf1_mj",  32'(bf1_mj),  e_mj);
      check_val("bf2_sel", 32'(bf2_sel), e_sel2);
      check_val("bf2_en",  32'(bf2_en),  e_en2);
      check_val("tw_addr", 32'(tw_addr), e_tw);
      check_val("do_en",   32'(do_en),   e_do);
    end
    check_val("err", 32'(err), 32'(err_exp));
    if (do_en) do_cnt++;
    reset = r;
    di_en = d;
    if (!r) begin
      starts.delete();
      sent    = 0;
      err_exp = 1'b0;
    end else if (d) begin
      if ((sent % F) == 0 && track) starts.push_back(cyc);
      sent++;
    end else if ((sent % F) != 0) begin
      err_exp = 1'b1;
    end
    cyc++;
  endtask

  task automatic send_frame();
    repeat (F) step(1'b1, 1'b1);
  endtask

  initial begin
    int gap;
    reset = 1'b1;
    di_en = 1'b0;
    #2 reset = 1'b0;

    // reset held, then long idle: nothing may stir
    repeat (10) step(1'b0, 1'b0);
    repeat (100) step(1'b0, 1'b1);

    // single frame, back-to-back pair, then random spacing
    do_cnt = 0;
    send_frame(); nfr++;
    repeat (150) step(1'b0, 1'b1);
    send_frame(); send_frame(); nfr += 2;
    repeat (150) step(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 70));
      repeat (gap) step(1'b0, 1'b1);
      send_frame(); nfr++;
    end
    repeat (150) step(1'b0, 1'b1);
    check_val("do_pulses", 32'(do_cnt), 32'(F * nfr));

    // reset in the middle of a frame discards it
    do_cnt = 0;
    repeat (40) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (150) step(1'b0, 1'b1);
    check_val("do_after_rst", 32'(do_cnt), 32'd0);
    send_frame();
    repeat (150) step(1'b0, 1'b1);

    // gap inside a frame raises a sticky error
    track = 1'b0;
    repeat (20) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    repeat (44) step(1'b1, 1'b1);
    repeat (150) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    track = 1'b1;
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    send_frame();
    repeat (150) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
